// File: rtl/int_ctrl_if.sv
// Bus between the core and the interrupt controller: request inputs, mask/enable
// strobes, accept handshake, and the saved flag/PC snapshot returned to the core.
interface int_ctrl_if;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       ei;
    logic       di;
    logic       int_ack;
    logic [3:0] kind;
    logic       cc_c;
    logic       cc_z;
    logic [7:0] pc;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_c;
    logic       int_z;
    logic [7:0] ret_pc;
    logic       ie;
    logic       in_service;

    modport master (
        output irq, mask_we, mask_wd, ei, di, int_ack, kind, cc_c, cc_z, pc,
        input  int_req, int_vec, int_c, int_z, ret_pc, ie, in_service
    );

    modport slave (
        input  irq, mask_we, mask_wd, ei, di, int_ack, kind, cc_c, cc_z, pc,
        output int_req, int_vec, int_c, int_z, ret_pc, ie, in_service
    );
endinterface

// File: rtl/int_ctrl.sv
// Four-source edge-triggered interrupt controller; snapshots carry/zero and the
// return PC on accept and holds them for the condition-code restore on RETI.
module int_ctrl (
    input logic       ck,
    input logic       res,
    input logic       ck2,
    int_ctrl_if.slave bus
);
    localparam logic [3:0] KIND_RETI = 4'b1000;

    typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;

    state_t     state, state_n;
    logic [3:0] mask;
    logic [3:0] pending, pending_n;
    logic [3:0] irq_d;
    logic [3:0] qualified;
    logic [3:0] clr;
    logic [1:0] src, src_n, first_src;
    logic       ie, ie_n;
    logic       capture;
    logic       int_c, int_z;
    logic [7:0] ret_pc;

    assign qualified = pending & mask;

    // Lowest index wins, so scan from the top and let lower bits overwrite.
    always_comb begin
        first_src = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (qualified[i]) first_src = 2'(i);
        end
    end

    always_comb begin
        state_n = state;
        src_n   = src;
        ie_n    = ie;
        capture = 1'b0;
        clr     = 4'b0000;
        if (bus.ei) ie_n = 1'b1;
        if (bus.di) ie_n = 1'b0;
        case (state)
            IDLE: begin
                if (ie && (qualified != 4'b0000)) begin
                    src_n   = first_src;
                    state_n = PEND;
                end
            end
            PEND: begin
                if (bus.di || !ie) begin
                    state_n = IDLE;
                end else if (bus.int_ack) begin
                    capture = 1'b1;
                    clr     = 4'b0001 << src;
                    ie_n    = 1'b0;
                    state_n = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.kind == KIND_RETI) begin
                    ie_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A fresh edge on the source being acknowledged must survive the clear.
    assign pending_n = (pending & ~clr) | (bus.irq & ~irq_d);

    always_ff @(posedge ck) begin
        if (!res) begin
            state   <= IDLE;
            mask    <= 4'b0000;
            pending <= 4'b0000;
            irq_d   <= 4'b0000;
            src     <= 2'd0;
            ie      <= 1'b0;
            int_c   <= 1'b0;
            int_z   <= 1'b0;
            ret_pc  <= 8'h00;
        end else if (!ck2) begin
            state   <= state_n;
            pending <= pending_n;
            irq_d   <= bus.irq;
            src     <= src_n;
            ie      <= ie_n;
            if (bus.mask_we) mask <= bus.mask_wd;
            if (capture) begin
                int_c  <= bus.cc_c;
                int_z  <= bus.cc_z;
                ret_pc <= bus.pc;
            end
        end
    end

    assign bus.int_req    = (state == PEND);
    assign bus.int_vec    = {4'b1111, src, 2'b00};
    assign bus.int_c      = int_c;
    assign bus.int_z      = int_z;
    assign bus.ret_pc     = ret_pc;
    assign bus.ie         = ie;
    assign bus.in_service = (state == SERVICE);
endmodule

// File: tb/tb_int_ctrl.sv
// Directed vector bench for int_ctrl: one row per rising edge, expected outputs
// after that edge computed by hand.
module tb_int_ctrl;
    logic ck;
    logic res;
    logic ck2;
    int   checks;
    int   errors;

    int_ctrl_if bus ();

    int_ctrl dut (
        .ck  (ck),
        .res (res),
        .ck2 (ck2),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        string      name;
        logic       res;
        logic       ck2;
        logic [3:0] irq;
        logic       mask_we;
        logic [3:0] mask_wd;
        logic       ei;
        logic       di;
        logic       ack;
        logic [3:0] kind;
        logic       cc_c;
        logic       cc_z;
        logic [7:0] pc;
        logic       req;
        logic [7:0] vec;
        logic       c;
        logic       z;
        logic [7:0] rpc;
        logic       ie;
        logic       srv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic r, logic k2, logic [3:0] irq, logic mwe,
                                logic [3:0] mwd, logic ei, logic di, logic ack, logic [3:0] kind,
                                logic ci, logic zi, logic [7:0] pci, logic req, logic [7:0] vec,
                                logic c, logic z, logic [7:0] rpc, logic ie, logic srv);
        vec_t v;
        v.name = n;   v.res = r;      v.ck2 = k2;      v.irq = irq;
        v.mask_we = mwe; v.mask_wd = mwd; v.ei = ei;  v.di = di;
        v.ack = ack;  v.kind = kind;  v.cc_c = ci;     v.cc_z = zi;
        v.pc = pci;   v.req = req;    v.vec = vec;     v.c = c;
        v.z = z;      v.rpc = rpc;    v.ie = ie;       v.srv = srv;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge ck);
        res         = v.res;
        ck2         = v.ck2;
        bus.irq     = v.irq;
        bus.mask_we = v.mask_we;
        bus.mask_wd = v.mask_wd;
        bus.ei      = v.ei;
        bus.di      = v.di;
        bus.int_ack = v.ack;
        bus.kind    = v.kind;
        bus.cc_c    = v.cc_c;
        bus.cc_z    = v.cc_z;
        bus.pc      = v.pc;
        @(posedge ck);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [20:0] act;
        logic [20:0] exp;
        act = {bus.int_req, bus.int_vec, bus.int_c, bus.int_z, bus.ret_pc, bus.ie, bus.in_service};
        exp = {v.req, v.vec, v.c, v.z, v.rpc, v.ie, v.srv};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: {req,vec,c,z,ret_pc,ie,srv} got %0b/%h/%0b%0b/%h/%0b%0b want %0b/%h/%0b%0b/%h/%0b%0b",
                     v.name, act[20], act[19:12], act[11], act[10], act[9:2], act[1], act[0],
                     exp[20], exp[19:12], exp[11], exp[10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic runRow(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        res = 1'b0; ck2 = 1'b0;
        bus.irq = 4'h0; bus.mask_we = 1'b0; bus.mask_wd = 4'h0; bus.ei = 1'b0; bus.di = 1'b0;
        bus.int_ack = 1'b0; bus.kind = 4'h0; bus.cc_c = 1'b0; bus.cc_z = 1'b0; bus.pc = 8'h00;

        //                 name                res k2 irq  we wd   ei di ak kind ci zi pc      req vec   c  z  rpc   ie srv
        tbl.push_back(mk("reset",             0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk("mask_wr_4",         1, 0, 4'h0, 1, 4'h4, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk("ei_set",            1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk("irq2_first_edge",   1, 0, 4'h4, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk("irq2_req_f8",       1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 8'hF8, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk("ack_capture",       1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h0, 1, 0, 8'h3A, 0, 8'hF8, 1, 0, 8'h3A, 0, 1));
        tbl.push_back(mk("service_hold",      1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 8'h55, 0, 8'hF8, 1, 0, 8'h3A, 0, 1));
        tbl.push_back(mk("reti_hold",         1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h8, 0, 1, 8'h55, 0, 8'hF8, 1, 0, 8'h3A, 1, 0));
        tbl.push_back(mk("idle_ignores",      1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h8, 0, 1, 8'h77, 0, 8'hF8, 1, 0, 8'h3A, 1, 0));
        tbl.push_back(mk("mask_wr_f",         1, 0, 4'h0, 1, 4'hF, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF8, 1, 0, 8'h3A, 1, 0));
        tbl.push_back(mk("irq31_first_edge",  1, 0, 4'hA, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF8, 1, 0, 8'h3A, 1, 0));
        tbl.push_back(mk("prio_f4",           1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 8'hF4, 1, 0, 8'h3A, 1, 0));
        tbl.push_back(mk("ack_src1",          1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h0, 0, 1, 8'h10, 0, 8'hF4, 0, 1, 8'h10, 0, 1));
        tbl.push_back(mk("ei_no_nest",        1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF4, 0, 1, 8'h10, 1, 1));
        tbl.push_back(mk("still_service",     1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF4, 0, 1, 8'h10, 1, 1));
        tbl.push_back(mk("reti_src1",         1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h8, 0, 0, 8'h00, 0, 8'hF4, 0, 1, 8'h10, 1, 0));
        tbl.push_back(mk("second_req_fc",     1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 8'hFC, 0, 1, 8'h10, 1, 0));
        tbl.push_back(mk("withdraw_di",       1, 0, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 0, 1, 8'h10, 0, 0));
        tbl.push_back(mk("withdraw_idle",     1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 0, 1, 8'h10, 0, 0));
        tbl.push_back(mk("ei_again",          1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 0, 1, 8'h10, 1, 0));
        tbl.push_back(mk("reassert_fc",       1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 8'hFC, 0, 1, 8'h10, 1, 0));
        tbl.push_back(mk("ck2_ack_lost",      1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 4'h0, 1, 0, 8'h99, 1, 8'hFC, 0, 1, 8'h10, 1, 0));
        tbl.push_back(mk("ck2_di_lost",       1, 1, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 8'h00, 1, 8'hFC, 0, 1, 8'h10, 1, 0));
        tbl.push_back(mk("ack_src3",          1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h0, 1, 1, 8'h20, 0, 8'hFC, 1, 1, 8'h20, 0, 1));
        tbl.push_back(mk("reti_src3",         1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h8, 0, 0, 8'h00, 0, 8'hFC, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk("mask_wr_e",         1, 0, 4'h0, 1, 4'hE, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk("irq0_masked_edge",  1, 0, 4'h1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk("irq0_masked",       1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk("irq0_still_masked", 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk("unmask_write",      1, 0, 4'h0, 1, 4'hF, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hFC, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk("unmask_req_f0",     1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 8'hF0, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk("ack_src0",          1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h0, 0, 0, 8'hC4, 0, 8'hF0, 0, 0, 8'hC4, 0, 1));
        tbl.push_back(mk("ei_di_di_wins",     1, 0, 4'h0, 0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'hC4, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end

        // Reset while in SERVICE with a pending bit; the reset edge has ck2=1.
        runRow(mk("svc_pend_set",      1, 0, 4'h4, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'hC4, 0, 1));
        runRow(mk("svc_reset",         0, 1, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 0, 0));
        runRow(mk("post_reset_ei",     1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        runRow(mk("post_reset_irq0",   1, 0, 4'h1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        runRow(mk("mask_zero_blocks",  1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        runRow(mk("mask_wr_4_again",   1, 0, 4'h0, 1, 4'h4, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        runRow(mk("pending2_lost",     1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        runRow(mk("mask_wr_f_again",   1, 0, 4'h0, 1, 4'hF, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 8'h00, 1, 0));
        runRow(mk("irq0_kept_req",     1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 8'hF0, 0, 0, 8'h00, 1, 0));

        // New edge on the source in the same cycle as its ack: the bit stays pending.
        runRow(mk("ack_with_edge",     1, 0, 4'h1, 0, 4'h0, 0, 0, 1, 4'h0, 1, 0, 8'hAB, 0, 8'hF0, 1, 0, 8'hAB, 0, 1));
        runRow(mk("reti_level_held",   1, 0, 4'h1, 0, 4'h0, 0, 0, 0, 4'h8, 0, 1, 8'h00, 0, 8'hF0, 1, 0, 8'hAB, 1, 0));
        runRow(mk("edge_set_won",      1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 8'hF0, 1, 0, 8'hAB, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the 8-bit core, and the producer side of the flag-save/restore path used by the condition-code register. It latches edge-triggered requests from four sources and prioritises them against a mask and a global enable. It raises a request to the core and, on the core's acknowledge, snapshots the live carry/zero flags and return PC. The saved flags are presented as `int_c`/`int_z` until the core executes RETI (`kind==4'b1000`), at which point the condition-code register restores from them.

## Interface
Parameters: none.
- `ck` input 1: system clock; all registers update on rising edge.
- `res` input 1: reset, synchronous, active-low; sampled on rising `ck` regardless of `ck2`.
- `ck2` input 1: phase qualifier; non-reset register updates occur only on edges where `ck2==1'b0`. Such edges are called enabled edges below.
- `irq` input 4: external requests; rising-edge sensitive; bit 0 has the highest priority.
- `mask_we` input 1: write strobe for the mask register.
- `mask_wd` input 4: mask data; a bit value of 1 enables that source.
- `ei` input 1: one-cycle pulse that sets global enable.
- `di` input 1: one-cycle pulse that clears global enable.
- `int_ack` input 1: core accepts the interrupt at an instruction boundary.
- `kind` input 4: decoded instruction kind; `4'b1000` is RETI.
- `cc_c` input 1: live carry flag, captured on accept.
- `cc_z` input 1: live zero flag, captured on accept.
- `pc` input 8: return address, captured on accept.
- `int_req` output 1: interrupt request to the core.
- `int_vec` output 8: handler address, `{4'b1111, src[1:0], 2'b00}`, giving F0/F4/F8/FC.
- `int_c` output 1: saved carry flag.
- `int_z` output 1: saved zero flag.
- `ret_pc` output 8: saved return PC.
- `ie` output 1: global interrupt enable.
- `in_service` output 1: high while in state SERVICE.

## Operation
- Reset values: `int_req=0`, `int_vec=8'hF0`, `int_c=0`, `int_z=0`, `ret_pc=0`, `ie=0`, `in_service=0`, `mask=4'b0000`, `pending=4'b0000`, `irq_d=0`, state IDLE.
- Edge detect: `irq_d` registers `irq` on every enabled edge. If `irq[i]==1` and `irq_d[i]==0`, then `pending[i]` is set.
- Pending bits persist while masked or while `ie=0`.
- The mask register is written when `mask_we==1`.
- `ie` control: `ei` sets `ie`, `di` clears it. If both are asserted in the same cycle, `di` wins.
- State IDLE: if `ie==1` and `(pending & mask)!=0`:
  - latch `src` as the lowest-index qualifying bit;
  - drive `int_vec` from `src`;
  - set `int_req=1`;
  - go to PEND.
- State PEND:
  - `int_vec` and `src` are frozen; later, higher-priority edges only set pending bits.
  - If `di` is asserted (or `ie` is already 0): `int_req=0`, return to IDLE, and `pending[src]` stays set.
  - Otherwise, if `int_ack`: capture `int_c<=cc_c`, `int_z<=cc_z`, `ret_pc<=pc`; clear `pending[src]`; `ie<=0`; `int_req<=0`; go to SERVICE.
  - If an edge on `src` coincides with the ack clear, the set wins and the bit stays pending.
- State SERVICE:
  - `in_service=1`.
  - `int_c`, `int_z` and `ret_pc` are held constant.
  - On RETI: `ie<=1`, go to IDLE. The saved outputs stay unchanged on that edge, so the condition-code register samples valid values.
  - `ei` during SERVICE sets `ie` but does not nest; there is no exit until RETI.
- Ignored inputs: `int_ack` outside PEND, and RETI outside SERVICE.

## Timing
- A rising edge on `irq` is seen at enabled edge E0, which sets `pending`. `int_req` goes high after E1, a latency of 2 enabled edges, when the source is unmasked and `ie=1`.
- `int_ack` sampled at enabled edge Ea: after Ea, `int_req=0`, the captured values are valid, and `in_service=1`.
- RETI sampled at enabled edge Er: after Er, `in_service=0` and `ie=1`. The next request can assert at the first enabled edge after Er.
- Edges with `ck2==1` change no state. A one-cycle `int_ack`, `ei`, `di` or `mask_we` pulse on such an edge is lost; the core aligns these pulses to `ck2==0`.
- Reset mid-operation (any state): all registers return to their reset values at that edge. In-flight pending requests are lost.

## Test plan
- Basic accept: reset, write mask `4'b0100`, `ei`, pulse `irq[2]`. Expect `int_req=1` and `int_vec=8'hF8` two enabled edges later. Ack with `cc_c=1`, `cc_z=0`, `pc=8'h3A`: expect `int_c=1`, `int_z=0`, `ret_pc=8'h3A`, `ie=0`, `in_service=1`.
- Priority: mask `4'b1111`, `ie=1`, `irq[3]` and `irq[1]` rising together. Expect `int_vec=8'hF4`. After RETI, expect a second request with `int_vec=8'hFC`.
- Restore hold: in SERVICE, change `cc_c`/`cc_z`, then issue `kind=4'b1000`. Expect `int_c`/`int_z` unchanged through the RETI edge, then IDLE with `ie=1`.
- Withdraw: in PEND, pulse `di`. Expect `int_req=0` next edge, `pending` still set. Pulse `ei`: expect `int_req` to reassert with the same vector.
- Phase gating and masking: pulse `int_ack` with `ck2=1`, expect no change. A masked `irq[0]` stays pending. Unmasking it yields `int_req` one enabled edge later.
- Reset in SERVICE: drive `res=0` for one edge. Expect all outputs at reset values, state IDLE, and `mask=0`.
